// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer: packs trace atoms into DCT frames under valid/ready, then drains and ends on flush
module nios2_oci_dct_packer #(
  parameter int ATOM_W = 3,
  parameter int ATOMS  = 10,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    atom_valid,
  input  logic [ATOM_W-1:0]       atom_data,
  output logic                    atom_ready,
  input  logic                    flush,
  output logic [ATOM_W*ATOMS-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    dct_valid,
  input  logic                    dct_ready,
  output logic                    test_ending,
  output logic                    test_has_ended
);
  localparam int W = ATOM_W * ATOMS;
  typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;
  state_t state;
  logic [W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic out_free, take, last;
  always_comb begin
    out_free = !dct_valid | dct_ready;
    last = acc_cnt == CNT_W'(ATOMS - 1);
    atom_ready = !reset & (state == RUN) & (!last | out_free);
    take = atom_valid & atom_ready;
    acc_nxt = acc | (W'(atom_data) << (ATOM_W * acc_cnt));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      acc <= '0;
      acc_cnt <= '0;
      dct_buffer <= '0;
      dct_count <= '0;
      dct_valid <= 1'b0;
      test_ending <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      if (dct_ready) dct_valid <= 1'b0;
      if (state == RUN) begin
        // the final atom bypasses the accumulator straight into the output register
        if (take && last) begin
          dct_buffer <= acc_nxt;
          dct_count <= CNT_W'(ATOMS);
          dct_valid <= 1'b1;
          acc <= '0;
          acc_cnt <= '0;
        end else if (take) begin
          acc <= acc_nxt;
          acc_cnt <= acc_cnt + 1'b1;
        end
        if (flush) begin
          state <= DRAIN;
          test_ending <= 1'b1;
        end
      end else if (state == DRAIN && out_free) begin
        if (acc_cnt != '0) begin
          dct_buffer <= acc;
          dct_count <= acc_cnt;
          dct_valid <= 1'b1;
          acc <= '0;
          acc_cnt <= '0;
        end else begin
          state <= ENDED;
          test_has_ended <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// tb_nios2_oci_dct_packer: directed stimulus with a frame scoreboard checked by an independent monitor
module tb_nios2_oci_dct_packer;
  logic clk = 0, reset = 1, atom_valid = 0, flush = 0, dct_ready = 0;
  logic [2:0] atom_data = '0;
  logic atom_ready, dct_valid, test_ending, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0] dct_count;
  typedef struct {logic [29:0] b; logic [3:0] c;} frame_t;
  frame_t sb[$];
  int vectors = 0, miscompares = 0;

  nios2_oci_dct_packer dut (
    .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom_data(atom_data),
    .atom_ready(atom_ready), .flush(flush), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .test_ending(test_ending),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every presented frame must match the head of the queue; it leaves the queue when taken
  always @(negedge clk) begin
    if (!reset && dct_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", {28'b0, dct_count}, 32'hFFFF_FFFF);
      end else begin
        check("frame_buf", {2'b0, dct_buffer}, {2'b0, sb[0].b});
        check("frame_cnt", {28'b0, dct_count}, {28'b0, sb[0].c});
        if (dct_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_atom(input logic [2:0] a);
    int n = 0;
    logic ok = 0;
    atom_valid = 1;
    atom_data = a;
    do begin
      @(negedge clk);
      ok = atom_ready;
      step();
      n++;
    end while (!ok && n < 50);
    if (!ok) check("atom_accept_timeout", 0, 1);
    atom_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    sb.delete();
    step();
    check("rst_valid", {31'b0, dct_valid}, 0);
    check("rst_buf", {2'b0, dct_buffer}, 0);
    check("rst_cnt", {28'b0, dct_count}, 0);
    check("rst_ending", {30'b0, test_ending, test_has_ended}, 0);
    check("rst_ready", {31'b0, atom_ready}, 0);
    reset = 0;
    step();
  endtask

  task automatic drained(input string name);
    repeat (3) step();
    check(name, sb.size(), 0);
  endtask

  initial begin
    step();
    do_reset();
    // T1: ten all-ones atoms
    dct_ready = 1;
    sb.push_back('{30'h3FFF_FFFF, 4'd10});
    repeat (10) send_atom(3'b111);
    check("t1_valid", {31'b0, dct_valid}, 1);
    check("t1_cnt", {28'b0, dct_count}, 10);
    drained("t1_drained");
    // T2: stalled output with a second frame behind it
    dct_ready = 0;
    sb.push_back('{30'h0924_9249, 4'd10});
    repeat (10) send_atom(3'b001);
    for (int k = 0; k < 9; k++) send_atom(3'(k % 8));
    sb.push_back('{30'h28FA_C688, 4'd10});
    atom_valid = 1;
    atom_data = 3'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_stall_ready", {31'b0, atom_ready}, 0);
      check("t2_stall_valid", {31'b0, dct_valid}, 1);
    end
    step();
    dct_ready = 1;
    send_atom(3'd5);
    check("t2_second_valid", {31'b0, dct_valid}, 1);
    drained("t2_drained");
    // T3: partial frame then flush
    send_atom(3'd5);
    send_atom(3'd2);
    send_atom(3'd7);
    sb.push_back('{30'h1D5, 4'd3});
    flush = 1;
    step();
    flush = 0;
    check("t3_ending", {30'b0, test_ending, test_has_ended}, 2'b10);
    check("t3_valid0", {31'b0, dct_valid}, 0);
    step();
    check("t3_valid1", {31'b0, dct_valid}, 1);
    check("t3_ended_early", {31'b0, test_has_ended}, 0);
    step();
    check("t3_ended", {30'b0, test_ending, test_has_ended}, 2'b11);
    check("t3_valid_after", {31'b0, dct_valid}, 0);
    check("t3_ready_after", {31'b0, atom_ready}, 0);
    drained("t3_drained");
    do_reset();
    // T4: flush with nothing accumulated
    flush = 1;
    step();
    flush = 0;
    check("t4_ending", {30'b0, test_ending, test_has_ended}, 2'b10);
    step();
    check("t4_ended", {30'b0, test_ending, test_has_ended}, 2'b11);
    check("t4_valid", {31'b0, dct_valid}, 0);
    drained("t4_drained");
    do_reset();
    // T5: flush together with the tenth atom
    repeat (9) send_atom(3'd6);
    sb.push_back('{30'h1EDB_6DB6, 4'd10});
    atom_valid = 1;
    atom_data = 3'd3;
    flush = 1;
    step();
    atom_valid = 0;
    flush = 0;
    check("t5_valid", {31'b0, dct_valid}, 1);
    check("t5_ending", {30'b0, test_ending, test_has_ended}, 2'b10);
    step();
    check("t5_ended", {30'b0, test_ending, test_has_ended}, 2'b11);
    check("t5_valid_after", {31'b0, dct_valid}, 0);
    drained("t5_drained");
    do_reset();
    // T6: reset with a pending frame and a partial accumulator
    dct_ready = 0;
    sb.push_back('{30'h0924_9249, 4'd10});
    repeat (10) send_atom(3'b001);
    repeat (4) send_atom(3'b010);
    do_reset();
    dct_ready = 1;
    send_atom(3'd4);
    send_atom(3'd1);
    sb.push_back('{30'h00C, 4'd2});
    flush = 1;
    step();
    flush = 0;
    repeat (2) step();
    check("t6_ended", {31'b0, test_has_ended}, 1);
    drained("t6_drained");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
